// File: rtl/multi_led_blinker_if.sv
// Configuration write port of multi_led_blinker: a one-cycle strobe carrying
// channel index, mode, blink half-period and PWM duty.
interface multi_led_blinker_if #(
  parameter int N_LED = 4,
  parameter int CNT_W = 16,
  parameter int PWM_W = 8
);
  localparam int CH_W = (N_LED > 1) ? $clog2(N_LED) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [PWM_W-1:0] cfg_duty;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty);
endinterface

// File: rtl/multi_led_blinker.sv
// N_LED independent LED channels (OFF/ON/BLINK/PWM) sharing one prescaler tick
// and one free-running PWM counter; every channel blinks at DEF_PERIOD out of reset.
module multi_led_blinker #(
  parameter int N_LED      = 4,
  parameter int PRESCALE   = 50000,
  parameter int CNT_W      = 16,
  parameter int PWM_W      = 8,
  parameter int DEF_PERIOD = 500
) (
  input  logic                clk,
  input  logic                rst,
  multi_led_blinker_if.slave  cfg,
  output logic [N_LED-1:0]    led,
  output logic                tick
);
  localparam int CH_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int PS_W = $clog2(PRESCALE);

  localparam logic [PS_W-1:0]  PS_ZERO  = PS_W'(0);
  localparam logic [PS_W-1:0]  PS_ONE   = PS_W'(1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P    = CNT_W'(DEF_PERIOD);
  localparam logic [PWM_W-1:0] PWM_ZERO = PWM_W'(0);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] phase_q, phase_d;
  mode_e            mode_q   [N_LED];
  mode_e            mode_d   [N_LED];
  logic [CNT_W-1:0] period_q [N_LED];
  logic [CNT_W-1:0] period_d [N_LED];
  logic [CNT_W-1:0] cnt_q    [N_LED];
  logic [CNT_W-1:0] cnt_d    [N_LED];
  logic [PWM_W-1:0] duty_q   [N_LED];
  logic [PWM_W-1:0] duty_d   [N_LED];

  // Shared timebase: tick is registered so it is high exactly while presc_q == PRESCALE-1.
  always_comb begin
    presc_d = (presc_q == PS_LAST) ? PS_ZERO : presc_q + PS_ONE;
    tick_d  = (presc_d == PS_LAST);
    pwm_d   = pwm_q + PWM_ONE;
  end

  // Per-channel next state; a config write overrides any tick on the same edge.
  always_comb begin
    logic             wr_s;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] cnt_s;
    logic             ph_s;
    led_d   = {N_LED{1'b0}};
    phase_d = phase_q;
    wr_s    = 1'b0;
    last_s  = CNT_ZERO;
    cnt_s   = CNT_ZERO;
    ph_s    = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      cnt_d[i]    = cnt_q[i];
      wr_s   = cfg.cfg_we && (int'(cfg.cfg_ch) < N_LED) && (cfg.cfg_ch == CH_W'(i));
      // period 0 behaves as 1, so the terminal count is 0 in both cases
      last_s = (period_q[i] == CNT_ZERO) ? CNT_ZERO : period_q[i] - CNT_ONE;
      cnt_s  = cnt_q[i];
      ph_s   = phase_q[i];

      case (mode_q[i])
        MODE_BLINK: begin
          if (tick_q) begin
            if (cnt_q[i] == last_s) begin
              cnt_s = CNT_ZERO;
              ph_s  = ~phase_q[i];
            end else begin
              cnt_s = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_s = cnt_q[i];
          end
        end
        default: begin
          cnt_s = CNT_ZERO;
          ph_s  = 1'b0;
        end
      endcase

      case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = ph_s;
        MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
        default:    led_d[i] = 1'b0;
      endcase

      if (wr_s) begin
        mode_d[i]   = mode_e'(cfg.cfg_mode);
        period_d[i] = cfg.cfg_period;
        duty_d[i]   = cfg.cfg_duty;
        cnt_d[i]    = CNT_ZERO;
        phase_d[i]  = 1'b0;
      end else begin
        cnt_d[i]    = cnt_s;
        phase_d[i]  = ph_s;
      end
    end
  end

  // State registers; reset brings every channel back to the default blink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= PS_ZERO;
      tick_q  <= 1'b0;
      pwm_q   <= PWM_ZERO;
      led_q   <= {N_LED{1'b0}};
      phase_q <= {N_LED{1'b0}};
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i]   <= MODE_BLINK;
        period_q[i] <= DEF_P;
        duty_q[i]   <= PWM_ZERO;
        cnt_q[i]    <= CNT_ZERO;
      end
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      pwm_q    <= pwm_d;
      led_q    <= led_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_multi_led_blinker.sv
// Self-checking bench for multi_led_blinker: directed table, hand sequences for
// timing corners, and random writes checked against a tick-counting reference model.
module tb_multi_led_blinker;
  localparam int N_LED      = 4;
  localparam int PRESCALE   = 4;
  localparam int CNT_W      = 16;
  localparam int PWM_W      = 8;
  localparam int DEF_PERIOD = 3;

  localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_PWM = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_LED-1:0] led;
  logic             tick;
  logic [2:0]       led3;
  logic             tick3;

  int n_checks = 0;
  int n_errors = 0;

  multi_led_blinker_if #(.N_LED(N_LED), .CNT_W(CNT_W), .PWM_W(PWM_W)) cfg_if ();

  multi_led_blinker #(
    .N_LED(N_LED), .PRESCALE(PRESCALE), .CNT_W(CNT_W), .PWM_W(PWM_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .led(led), .tick(tick)
  );

  // Three-channel copy on the same write port: index 3 is out of range for it.
  multi_led_blinker #(
    .N_LED(3), .PRESCALE(PRESCALE), .CNT_W(CNT_W), .PWM_W(PWM_W), .DEF_PERIOD(DEF_PERIOD)
  ) dut3 (
    .clk(clk), .rst(rst), .cfg(cfg_if), .led(led3), .tick(tick3)
  );

  always #5 clk = ~clk;

  // Reference model: a BLINK channel's phase is (ticks seen since restart / eff_period) mod 2.
  int               m_k;
  int               m_ticks  [N_LED];
  int               m_mode   [N_LED];
  int               m_period [N_LED];
  int               m_duty   [N_LED];
  logic [N_LED-1:0] m_led;
  logic             m_tick;
  int               m_tk, m_pwm, m_eff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    = 0;
      m_led  = '0;
      m_tick = 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        m_ticks[i]  = 0;
        m_mode[i]   = M_BLINK;
        m_period[i] = DEF_PERIOD;
        m_duty[i]   = 0;
      end
    end else begin
      m_tk  = ((m_k % PRESCALE) == PRESCALE - 1) ? 1 : 0;
      m_pwm = m_k % (1 << PWM_W);
      for (int i = 0; i < N_LED; i++) begin
        m_eff = (m_period[i] == 0) ? 1 : m_period[i];
        case (m_mode[i])
          M_OFF:   m_led[i] = 1'b0;
          M_ON:    m_led[i] = 1'b1;
          M_BLINK: m_led[i] = (((m_ticks[i] + m_tk) / m_eff) % 2) == 1;
          default: m_led[i] = (m_pwm < m_duty[i]);
        endcase
        if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == i) begin
          m_mode[i]   = int'(cfg_if.cfg_mode);
          m_period[i] = int'(cfg_if.cfg_period);
          m_duty[i]   = int'(cfg_if.cfg_duty);
          m_ticks[i]  = 0;
        end else if (m_mode[i] == M_BLINK && m_tk == 1) begin
          m_ticks[i] = m_ticks[i] + 1;
        end
      end
      m_k    = m_k + 1;
      m_tick = (m_k % PRESCALE) == PRESCALE - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge, then compare both DUTs against the model on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("model_led", 32'(led), 32'(m_led));
    check("model_tick", 32'(tick), 32'(m_tick));
    check("model_led_n3", 32'(led3), 32'(m_led[2:0]));
    check("model_tick_n3", 32'(tick3), 32'(m_tick));
  endtask

  task automatic wr(input int ch, input int mode, input int period, input int duty);
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_period = 16'(period);
    cfg_if.cfg_duty   = 8'(duty);
    step();
    cfg_if.cfg_we     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_led", 32'(led), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_led_n3", 32'(led3), 32'h0);
  endtask

  // Default blink: tick every 4 clk, all LEDs toggle every 12 clk starting at edge 12.
  task automatic seq_default(input string tag);
    for (int n = 1; n <= 36; n++) begin
      step();
      check({tag, "_led"}, 32'(led), (((n / 12) % 2) == 1) ? 32'hF : 32'h0);
      check({tag, "_tick"}, 32'(tick), ((n % 4) == 3) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic measure(input int ch, input int ngaps, input int gap, input int budget,
                         input string name);
    logic prev;
    int   last;
    int   seen;
    int   cyc;
    prev = led[ch];
    last = -1;
    seen = 0;
    cyc  = 0;
    while (seen < ngaps && cyc < budget) begin
      step();
      cyc++;
      if (led[ch] !== prev) begin
        prev = led[ch];
        if (last >= 0) begin
          check(name, 32'(cyc - last), 32'(gap));
          seen++;
        end
        last = cyc;
      end
    end
    if (seen < ngaps) check({name, "_timeout"}, 32'(seen), 32'(ngaps));
  endtask

  typedef struct {
    logic       we;
    int         ch;
    int         mode;
    int         period;
    int         duty;
    int         extra;
    logic [3:0] mask;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [8];
  int   duties [3];
  int   cnt;
  int   wait_n;

  initial begin
    cfg_if.cfg_we     = 1'b0;
    cfg_if.cfg_ch     = 2'd0;
    cfg_if.cfg_mode   = 2'd0;
    cfg_if.cfg_period = 16'd0;
    cfg_if.cfg_duty   = 8'd0;

    vecs[0] = '{1'b1, 1, M_ON,    0,    0, 1,  4'b0010, 4'b0010};
    vecs[1] = '{1'b1, 2, M_OFF,   0,    0, 1,  4'b0110, 4'b0010};
    vecs[2] = '{1'b0, 0, M_OFF,   0,    0, 30, 4'b0110, 4'b0010};
    vecs[3] = '{1'b1, 0, M_PWM,   0,    0, 1,  4'b0111, 4'b0010};
    vecs[4] = '{1'b1, 3, M_BLINK, 1000, 0, 1,  4'b1111, 4'b0010};
    vecs[5] = '{1'b0, 0, M_OFF,   0,    0, 40, 4'b1111, 4'b0010};
    vecs[6] = '{1'b1, 2, M_ON,    0,    0, 1,  4'b1111, 4'b0110};
    vecs[7] = '{1'b1, 1, M_OFF,   0,    0, 1,  4'b1111, 4'b0100};
    duties  = '{64, 0, 255};

    do_reset();
    seq_default("default");

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].we) wr(vecs[v].ch, vecs[v].mode, vecs[v].period, vecs[v].duty);
      else step();
      repeat (vecs[v].extra) step();
      check($sformatf("vec%0d", v), 32'(led & vecs[v].mask), 32'(vecs[v].exp));
    end

    wr(0, M_BLINK, 0, 0);
    measure(0, 3, 4, 40, "period0_gap");
    wr(0, M_BLINK, 5, 0);
    step();
    check("period5_start", 32'(led[0]), 32'h0);
    measure(0, 2, 20, 100, "period5_gap");

    foreach (duties[d]) begin
      wr(3, M_PWM, 0, duties[d]);
      cnt = 0;
      for (int c = 0; c < 256; c++) begin
        step();
        cnt += int'(led[3]);
      end
      check($sformatf("pwm_duty%0d", duties[d]), 32'(cnt), 32'(duties[d]));
    end

    wait_n = 0;
    while (tick !== 1'b1 && wait_n < 10) begin
      step();
      wait_n++;
    end
    check("tick_seen", 32'(tick), 32'h1);
    wr(1, M_BLINK, 3, 0);
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 11) check("tickwr_hold", 32'(led[1]), 32'h0);
      if (n == 12) check("tickwr_toggle", 32'(led[1]), 32'h1);
    end

    for (int c = 0; c < 3000; c++) begin
      cfg_if.cfg_we     = ($urandom_range(7) == 0);
      cfg_if.cfg_ch     = 2'($urandom_range(3));
      cfg_if.cfg_mode   = 2'($urandom_range(3));
      cfg_if.cfg_period = 16'($urandom_range(6));
      cfg_if.cfg_duty   = 8'($urandom_range(255));
      step();
    end
    cfg_if.cfg_we = 1'b0;

    do_reset();
    repeat (15) step();
    check("pre_rst_led", 32'(led), 32'hF);
    #1 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_tick", 32'(tick), 32'h0);
    check("async_rst_led_n3", 32'(led3), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seq_default("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
